// File: rtl/licznik_czasu_param.sv
// BCD time-of-day counter: optional seconds, 12/24-hour mode, validated preset load
// and a one-cycle pulse when the count rolls over into midnight.
module licznik_czasu_param #(
  parameter int H24    = 1,
  parameter int SEC_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       tick,
  input  logic       inc_sek,
  input  logic       inc_min,
  input  logic       inc_godz,
  input  logic       load,
  input  logic [7:0] load_sek,
  input  logic [7:0] load_min,
  input  logic [7:0] load_godz,
  input  logic       load_pm,
  output logic [3:0] sek_jed,
  output logic [3:0] sek_dzie,
  output logic [3:0] min_jed,
  output logic [3:0] min_dzie,
  output logic [3:0] godz_jed,
  output logic [3:0] godz_dzie,
  output logic       pm,
  output logic       day_tick,
  output logic       load_err
);

  localparam logic [7:0] HOUR_RST = (H24 != 0) ? 8'h00 : 8'h12;

  logic [7:0] sek_r, min_r, godz_r;
  logic       pm_r, day_r, err_r;
  logic [7:0] sek_n_s, min_n_s, godz_n_s;
  logic       pm_n_s, day_n_s, err_n_s;
  logic [8:0] sek_c_s, min_c_s, hr_c_s;
  logic       sek_ok_s, min_ok_s, hr_ok_s, load_ok_s;

  function automatic logic nib_ok(input logic [7:0] v);
    nib_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // {carry, next} for a 00..59 field
  function automatic logic [8:0] inc59(input logic [7:0] v);
    if (v >= 8'h59) inc59 = {1'b1, 8'h00};
    else            inc59 = {1'b0, bcd_inc(v)};
  endfunction

  // {pm, hours} after one hour step; 12-hour mode flips pm on 11->12 only
  function automatic logic [8:0] hr_inc(input logic [7:0] h, input logic p);
    logic [7:0] b;
    b = bcd_inc(h);
    if (H24 != 0) begin
      if (h >= 8'h23) hr_inc = {1'b0, 8'h00};
      else            hr_inc = {(b >= 8'h12), b};
    end else begin
      if (h >= 8'h12)      hr_inc = {p, 8'h01};
      else if (h == 8'h11) hr_inc = {~p, 8'h12};
      else                 hr_inc = {p, b};
    end
  endfunction

  // preset validation and single-step candidates for each field
  always_comb begin
    sek_ok_s  = (SEC_EN == 0) || (nib_ok(load_sek) && (load_sek <= 8'h59));
    min_ok_s  = nib_ok(load_min) && (load_min <= 8'h59);
    if (H24 != 0) hr_ok_s = nib_ok(load_godz) && (load_godz <= 8'h23);
    else          hr_ok_s = nib_ok(load_godz) && (load_godz >= 8'h01) && (load_godz <= 8'h12);
    load_ok_s = sek_ok_s && min_ok_s && hr_ok_s;
    sek_c_s   = inc59(sek_r);
    min_c_s   = inc59(min_r);
    hr_c_s    = hr_inc(godz_r, pm_r);
  end

  // next state: load beats counting, counting beats set-mode steps
  always_comb begin
    sek_n_s  = sek_r;
    min_n_s  = min_r;
    godz_n_s = godz_r;
    pm_n_s   = pm_r;
    day_n_s  = 1'b0;
    err_n_s  = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        sek_n_s  = (SEC_EN != 0) ? load_sek : 8'h00;
        min_n_s  = load_min;
        godz_n_s = load_godz;
        pm_n_s   = (H24 != 0) ? (load_godz >= 8'h12) : load_pm;
      end else begin
        err_n_s = 1'b1;
      end
    end else if (run && tick) begin
      if (SEC_EN != 0) sek_n_s = sek_c_s[7:0];
      else             sek_n_s = 8'h00;
      if ((SEC_EN == 0) || sek_c_s[8]) begin
        min_n_s = min_c_s[7:0];
        if (min_c_s[8]) begin
          {pm_n_s, godz_n_s} = hr_c_s;
          if (H24 != 0) day_n_s = (godz_r == 8'h23);
          else          day_n_s = (godz_r == 8'h11) && pm_r;
        end else begin
          godz_n_s = godz_r;
        end
      end else begin
        min_n_s = min_r;
      end
    end else if (!run) begin
      if (inc_sek && (SEC_EN != 0)) sek_n_s = sek_c_s[7:0];
      else                          sek_n_s = sek_r;
      if (inc_min) min_n_s = min_c_s[7:0];
      else         min_n_s = min_r;
      if (inc_godz) {pm_n_s, godz_n_s} = hr_c_s;
      else          {pm_n_s, godz_n_s} = {pm_r, godz_r};
    end else begin
      day_n_s = 1'b0;
    end
  end

  // state and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sek_r  <= 8'h00;
      min_r  <= 8'h00;
      godz_r <= HOUR_RST;
      pm_r   <= 1'b0;
      day_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      sek_r  <= sek_n_s;
      min_r  <= min_n_s;
      godz_r <= godz_n_s;
      pm_r   <= pm_n_s;
      day_r  <= day_n_s;
      err_r  <= err_n_s;
    end
  end

  assign sek_jed   = sek_r[3:0];
  assign sek_dzie  = sek_r[7:4];
  assign min_jed   = min_r[3:0];
  assign min_dzie  = min_r[7:4];
  assign godz_jed  = godz_r[3:0];
  assign godz_dzie = godz_r[7:4];
  assign pm        = pm_r;
  assign day_tick  = day_r;
  assign load_err  = err_r;

endmodule

// File: tb/tb_licznik_czasu_param.sv
// Scoreboard bench for licznik_czasu_param: three instances (24h+sec, 12h+sec, 24h no sec)
// share the same stimulus; each step names the instance whose output it checks.
module tb_licznik_czasu_param;

  logic clk = 1'b0;
  logic rst, run, tick, inc_sek, inc_min, inc_godz, load, load_pm;
  logic [7:0] load_sek, load_min, load_godz;
  logic [3:0] sj [3], sd [3], mj [3], md [3], gj [3], gd [3];
  logic pm_o [3], day_o [3], err_o [3];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         dut;
    logic       ld;
    logic [7:0] h, m, s;
    logic       lpm, rn, tk, is, im, ih;
    logic [26:0] exp;
    string      nm;
  } step_t;

  step_t stq[$];
  step_t sb[$];

  always #5 clk = ~clk;

  licznik_czasu_param #(.H24(1), .SEC_EN(1)) d0 (
    .clk(clk), .rst(rst), .run(run), .tick(tick), .inc_sek(inc_sek), .inc_min(inc_min),
    .inc_godz(inc_godz), .load(load), .load_sek(load_sek), .load_min(load_min),
    .load_godz(load_godz), .load_pm(load_pm), .sek_jed(sj[0]), .sek_dzie(sd[0]),
    .min_jed(mj[0]), .min_dzie(md[0]), .godz_jed(gj[0]), .godz_dzie(gd[0]),
    .pm(pm_o[0]), .day_tick(day_o[0]), .load_err(err_o[0]));

  licznik_czasu_param #(.H24(0), .SEC_EN(1)) d1 (
    .clk(clk), .rst(rst), .run(run), .tick(tick), .inc_sek(inc_sek), .inc_min(inc_min),
    .inc_godz(inc_godz), .load(load), .load_sek(load_sek), .load_min(load_min),
    .load_godz(load_godz), .load_pm(load_pm), .sek_jed(sj[1]), .sek_dzie(sd[1]),
    .min_jed(mj[1]), .min_dzie(md[1]), .godz_jed(gj[1]), .godz_dzie(gd[1]),
    .pm(pm_o[1]), .day_tick(day_o[1]), .load_err(err_o[1]));

  licznik_czasu_param #(.H24(1), .SEC_EN(0)) d2 (
    .clk(clk), .rst(rst), .run(run), .tick(tick), .inc_sek(inc_sek), .inc_min(inc_min),
    .inc_godz(inc_godz), .load(load), .load_sek(load_sek), .load_min(load_min),
    .load_godz(load_godz), .load_pm(load_pm), .sek_jed(sj[2]), .sek_dzie(sd[2]),
    .min_jed(mj[2]), .min_dzie(md[2]), .godz_jed(gj[2]), .godz_dzie(gd[2]),
    .pm(pm_o[2]), .day_tick(day_o[2]), .load_err(err_o[2]));

  function automatic logic [26:0] ex(input logic p, input logic d, input logic e,
                                     input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ex = {p, d, e, h, m, s};
  endfunction

  function automatic logic [26:0] obs(input int d);
    case (d)
      0:       obs = {pm_o[0], day_o[0], err_o[0], gd[0], gj[0], md[0], mj[0], sd[0], sj[0]};
      1:       obs = {pm_o[1], day_o[1], err_o[1], gd[1], gj[1], md[1], mj[1], sd[1], sj[1]};
      2:       obs = {pm_o[2], day_o[2], err_o[2], gd[2], gj[2], md[2], mj[2], sd[2], sj[2]};
      default: obs = 27'h7ffffff;
    endcase
  endfunction

  task automatic st(input int dut, input logic ld, input logic [7:0] h, input logic [7:0] m,
                    input logic [7:0] s, input logic lpm, input logic rn, input logic tk,
                    input logic is, input logic im, input logic ih, input logic [26:0] exp,
                    input string nm);
    step_t x;
    x.dut = dut; x.ld = ld; x.h = h; x.m = m; x.s = s; x.lpm = lpm;
    x.rn = rn; x.tk = tk; x.is = is; x.im = im; x.ih = ih; x.exp = exp; x.nm = nm;
    stq.push_back(x);
  endtask

  task automatic drive(input step_t x);
    load = x.ld; load_godz = x.h; load_min = x.m; load_sek = x.s; load_pm = x.lpm;
    run = x.rn; tick = x.tk; inc_sek = x.is; inc_min = x.im; inc_godz = x.ih;
  endtask

  task automatic test_reset();
    step_t cur;
    drive('{dut: 0, ld: 1'b0, h: 8'h00, m: 8'h00, s: 8'h00, lpm: 1'b0, rn: 1'b0, tk: 1'b0,
            is: 1'b0, im: 1'b0, ih: 1'b0, exp: 27'h0, nm: "idle"});
    rst = 1'b1;
    #2;
    st(0, 0,0,0,0,0, 0,0,0,0,0, ex(0,0,0,8'h00,8'h00,8'h00), "reset_h24");
    st(1, 0,0,0,0,0, 0,0,0,0,0, ex(0,0,0,8'h12,8'h00,8'h00), "reset_h12");
    st(2, 0,0,0,0,0, 0,0,0,0,0, ex(0,0,0,8'h00,8'h00,8'h00), "reset_nosec");
    while (stq.size() > 0) begin
      sb.push_back(stq.pop_front());
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_midnight_h24();
    step_t cur;
    st(0, 1,8'h23,8'h59,8'h58,0, 1,0,0,0,0, ex(1,0,0,8'h23,8'h59,8'h58), "load_235958");
    st(0, 0,0,0,0,0, 1,1,0,0,0, ex(1,0,0,8'h23,8'h59,8'h59), "tick_235959");
    st(0, 0,0,0,0,0, 1,1,0,0,0, ex(0,1,0,8'h00,8'h00,8'h00), "tick_midnight");
    st(0, 0,0,0,0,0, 1,0,0,0,0, ex(0,0,0,8'h00,8'h00,8'h00), "day_tick_one_cycle");
    st(0, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h00,8'h00,8'h01), "tick_after_midnight");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_midnight_h12();
    step_t cur;
    st(1, 1,8'h11,8'h59,8'h59,0, 1,0,0,0,0, ex(0,0,0,8'h11,8'h59,8'h59), "load_115959am");
    st(1, 0,0,0,0,0, 1,1,0,0,0, ex(1,0,0,8'h12,8'h00,8'h00), "noon");
    st(1, 1,8'h11,8'h59,8'h59,1, 1,0,0,0,0, ex(1,0,0,8'h11,8'h59,8'h59), "load_115959pm");
    st(1, 0,0,0,0,0, 1,1,0,0,0, ex(0,1,0,8'h12,8'h00,8'h00), "midnight_12h");
    st(1, 1,8'h12,8'h59,8'h59,0, 1,0,0,0,0, ex(0,0,0,8'h12,8'h59,8'h59), "load_125959");
    st(1, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h01,8'h00,8'h00), "wrap_12_to_01");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_set_mode();
    step_t cur;
    st(0, 1,8'h22,8'h59,8'h50,0, 0,0,0,0,0, ex(1,0,0,8'h22,8'h59,8'h50), "load_225950");
    st(0, 0,0,0,0,0, 0,0,0,1,1, ex(1,0,0,8'h23,8'h00,8'h50), "inc_min_godz");
    st(0, 0,0,0,0,0, 0,0,0,0,1, ex(0,0,0,8'h00,8'h00,8'h50), "inc_godz_wrap");
    st(0, 0,0,0,0,0, 0,0,0,0,1, ex(0,0,0,8'h01,8'h00,8'h50), "inc_godz_01");
    st(0, 0,0,0,0,0, 0,1,0,0,0, ex(0,0,0,8'h01,8'h00,8'h50), "tick_ignored_set");
    st(0, 0,0,0,0,0, 0,0,1,0,0, ex(0,0,0,8'h01,8'h00,8'h51), "inc_sek");
    st(1, 1,8'h10,8'h20,8'h30,0, 0,0,0,0,0, ex(0,0,0,8'h10,8'h20,8'h30), "load_12h_set");
    st(1, 0,0,0,0,0, 0,0,0,0,1, ex(0,0,0,8'h11,8'h20,8'h30), "inc_12h_11");
    st(1, 0,0,0,0,0, 0,0,0,0,1, ex(1,0,0,8'h12,8'h20,8'h30), "inc_12h_pm");
    st(1, 0,0,0,0,0, 0,0,0,0,1, ex(1,0,0,8'h01,8'h20,8'h30), "inc_12h_01");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_load_reject();
    step_t cur;
    st(0, 1,8'h10,8'h20,8'h30,0, 0,0,0,0,0, ex(0,0,0,8'h10,8'h20,8'h30), "load_valid");
    st(0, 1,8'h24,8'h00,8'h00,0, 0,0,0,0,0, ex(0,0,1,8'h10,8'h20,8'h30), "reject_24h");
    st(0, 0,0,0,0,0, 0,0,0,0,0, ex(0,0,0,8'h10,8'h20,8'h30), "err_one_cycle");
    st(0, 1,8'h12,8'h60,8'h00,0, 0,0,0,0,0, ex(0,0,1,8'h10,8'h20,8'h30), "reject_min60");
    st(0, 1,8'h0a,8'h00,8'h00,0, 0,0,0,0,0, ex(0,0,1,8'h10,8'h20,8'h30), "reject_nibble");
    st(1, 1,8'h00,8'h00,8'h00,0, 0,0,0,0,0, ex(0,0,1,8'h10,8'h20,8'h30), "reject_00_12h");
    st(1, 0,0,0,0,0, 0,0,0,0,0, ex(0,0,0,8'h10,8'h20,8'h30), "err_clear_12h");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t cur;
    st(0, 1,8'h05,8'h05,8'h05,0, 1,0,0,0,0, ex(0,0,0,8'h05,8'h05,8'h05), "preload");
    st(0, 1,8'h10,8'h20,8'h30,0, 1,1,0,0,0, ex(0,0,0,8'h10,8'h20,8'h30), "load_beats_tick");
    st(0, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h10,8'h20,8'h31), "tick_after_load");
    st(0, 0,0,0,0,0, 1,1,1,1,1, ex(0,0,0,8'h10,8'h20,8'h32), "tick_beats_inc");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_no_seconds();
    step_t cur;
    st(2, 1,8'h09,8'h59,8'h45,0, 1,0,0,0,0, ex(0,0,0,8'h09,8'h59,8'h00), "nosec_load");
    st(2, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h10,8'h00,8'h00), "nosec_tick");
    st(2, 0,0,0,0,0, 0,0,1,0,0, ex(0,0,0,8'h10,8'h00,8'h00), "nosec_inc_sek");
    st(2, 1,8'h23,8'h59,8'h77,0, 1,0,0,0,0, ex(1,0,0,8'h23,8'h59,8'h00), "nosec_sek_unchecked");
    st(2, 0,0,0,0,0, 1,1,0,0,0, ex(0,1,0,8'h00,8'h00,8'h00), "nosec_midnight");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t cur;
    st(2, 1,8'h09,8'h59,8'h00,0, 1,0,0,0,0, ex(0,0,0,8'h09,8'h59,8'h00), "pre_rst_load");
    st(2, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h10,8'h00,8'h00), "pre_rst_tick");
    while (stq.size() > 0) begin
      cur = stq.pop_front();
      drive(cur);
      sb.push_back(cur);
      @(posedge clk); #1;
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    st(2, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h00,8'h00,8'h00), "async_rst_nosec");
    st(1, 0,0,0,0,0, 1,1,0,0,0, ex(0,0,0,8'h12,8'h00,8'h00), "async_rst_12h");
    while (stq.size() > 0) begin
      sb.push_back(stq.pop_front());
      cur = sb.pop_front();
      checks++;
      if (obs(cur.dut) !== cur.exp) begin
        failures++;
        $display("FAIL %s dut%0d got=%h expected=%h", cur.nm, cur.dut, obs(cur.dut), cur.exp);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_midnight_h24();
    test_midnight_h12();
    test_set_mode();
    test_load_reject();
    test_back_to_back();
    test_no_seconds();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
